// File: rtl/reset_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reset_sched_pkg
// Brief    : Shared state encoding and event-counter constants for the
//            reset request scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package reset_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_ASSERT   = 2'd1;
    localparam state_t ST_COOLDOWN = 2'd2;

    localparam int EVT_W = 8;
    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

    // Index width for a requester count; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; searches upward from ptr+1
//            with wrap-around and returns the first set request.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    // Two passes: indices above the pointer first, then the wrapped part.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i > int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i <= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reset_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : reset_req_scheduler
// Brief    : Serialises monitor force_reset requests round-robin into timed
//            host reset pulses, each followed by a cooldown window.
// Revision : 1.0 - initial release
// ============================================================================
module reset_req_scheduler
    import reset_sched_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [NUM_REQ-1:0]            req_mask,
    output logic                          sys_reset_out,
    output logic                          busy,
    output logic                          grant_valid,
    output logic [id_width(NUM_REQ)-1:0]  grant_id,
    output logic [NUM_REQ-1:0]            ack_out,
    output logic [EVT_W-1:0]              event_count
);

    localparam int ID_W = id_width(NUM_REQ);

    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_COOL_LOAD =
        (COOLDOWN_CYCLES > 0) ? CNT_W'(COOLDOWN_CYCLES - 1) : '0;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [ID_W-1:0]      r_ptr;
    logic [NUM_REQ-1:0]   r_req_prev;
    logic [NUM_REQ-1:0]   r_pending;

    logic [NUM_REQ-1:0]   w_req_rise;
    logic [NUM_REQ-1:0]   w_arb_grant;
    logic [ID_W-1:0]      w_arb_id;
    logic                 w_arb_any;
    logic                 w_do_grant;
    logic [NUM_REQ-1:0]   w_clr;

    assign w_req_rise = req_in & ~r_req_prev;
    assign w_do_grant = (r_state == ST_IDLE) && w_arb_any;
    assign w_clr      = w_do_grant ? w_arb_grant : '0;

    assign sys_reset_out = (r_state == ST_ASSERT);
    assign busy          = (r_state == ST_ASSERT) || (r_state == ST_COOLDOWN);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (r_pending & req_mask),
        .ptr      (r_ptr),
        .grant    (w_arb_grant),
        .grant_id (w_arb_id),
        .any      (w_arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_req_prev  <= '0;
            r_pending   <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ack_out     <= '0;
            event_count <= '0;
        end else begin
            r_req_prev  <= req_in;
            // A rise on the bit being granted this edge survives the clear.
            r_pending   <= ((r_pending & ~w_clr) | w_req_rise) & req_mask;
            grant_valid <= 1'b0;
            ack_out     <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        grant_valid <= 1'b1;
                        ack_out     <= w_arb_grant;
                        grant_id    <= w_arb_id;
                        r_ptr       <= w_arb_id;
                        r_cnt       <= C_HOLD_LOAD;
                        r_state     <= ST_ASSERT;
                        if (event_count != EVT_MAX) begin
                            event_count <= event_count + EVT_W'(1);
                        end
                    end
                end
                ST_ASSERT: begin
                    if (r_cnt == '0) begin
                        if (COOLDOWN_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_COOLDOWN;
                            r_cnt   <= C_COOL_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_COOLDOWN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
